// File: rtl/add_cla32.sv
// Registered 32-bit unsigned adder: eight 4-bit carry-lookahead slices, carries ripple between slices.
// Define ADD_INPUT_REG_EN to add an input register stage on a/b/r (2-edge latency instead of 1).
module add_cla32 (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        r,
  output logic [31:0] s
);

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_ld;
  logic [31:0] w_sum;
  logic [7:0]  w_c;

`ifdef ADD_INPUT_REG_EN
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_ld;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a  <= '0;
      r_b  <= '0;
      r_ld <= 1'b0;
    end else begin
      r_a  <= a;
      r_b  <= b;
      r_ld <= r;
    end
  end

  assign w_a  = r_a;
  assign w_b  = r_b;
  assign w_ld = r_ld;
`else
  assign w_a  = a;
  assign w_b  = b;
  assign w_ld = r;
`endif

  assign w_c[0] = 1'b0;

  for (genvar k = 0; k < 8; k++) begin : g_slice
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_ci;

    assign w_g = w_a[4*k +: 4] & w_b[4*k +: 4];
    assign w_p = w_a[4*k +: 4] ^ w_b[4*k +: 4];

    // Lookahead: each bit's carry is formed directly from g/p and the slice carry-in.
    assign w_ci[0] = w_c[k];
    assign w_ci[1] = w_g[0] | (w_p[0] & w_c[k]);
    assign w_ci[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[k]);
    assign w_ci[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_c[k]);

    assign w_sum[4*k +: 4] = w_p ^ w_ci;

    // The top slice's carry-out is the discarded bit-32 carry, so it is never built.
    if (k < 7) begin : g_cout
      assign w_c[k+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                      | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                      | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[k]);
    end
  end

  // NOTE: only real datapath registers are reset here; there are no memories in this block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s <= '0;
    end else if (w_ld) begin
      s <= w_sum;
    end
  end

endmodule

// File: tb/tb_add_cla32.sv
// Scoreboard bench for add_cla32: driver pushes expected sums tagged with the edge they are due,
// a monitor pops and compares after each rising edge.
module tb_add_cla32;

`ifdef ADD_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rstn;
  logic [31:0] a;
  logic [31:0] b;
  logic        r;
  logic [31:0] s;

  typedef struct {
    int          due;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] acc = '0;

  add_cla32 dut (
    .clk  (clk),
    .rstn (rstn),
    .a    (a),
    .b    (b),
    .r    (r),
    .s    (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference: the output register holds the most recent loaded (a+b) mod 2^32.
  task automatic drive(input logic [31:0] ta, input logic [31:0] tb_v, input logic tr,
                       input logic use_exp, input logic [31:0] texp);
    exp_t e;
    @(negedge clk);
    a = ta;
    b = tb_v;
    r = tr;
    if (tr) acc = ta + tb_v;
    if (use_exp) acc = texp;
    e.due = cyc + LAT;
    e.exp = acc;
    q.push_back(e);
  endtask

  task automatic reset_pulse();
    exp_t e;
    @(negedge clk);
    a = $urandom;
    b = $urandom;
    r = 1'b0;
    #2 rstn = 1'b0;
    #1 check("reset_pulse_async", s, 32'h0);
    q.delete();
    acc = '0;
    for (int d = cyc + 1; d <= cyc + LAT; d++) begin
      e.due = d;
      e.exp = 32'h0;
      q.push_back(e);
    end
    #1 rstn = 1'b1;
  endtask

  // Monitor: no valid strobe exists, so every edge with a due expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("sum", s, e.exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b1;
    a    = 32'h0;
    b    = 32'h0;
    r    = 1'b0;
    #1 rstn = 1'b0;
    a = 32'hDEADBEEF;
    b = 32'h12345678;
    #1 check("reset_async", s, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      check("reset_held", s, 32'h0);
    end
    @(negedge clk);
    r    = 1'b0;
    rstn = 1'b1;

    // Directed: basic add, hold, wrap, back-to-back carry across slice boundaries.
    drive(32'h00000CFF, 32'h000003BB, 1'b1, 1'b1, 32'h000010BA);
    drive(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1, 32'h000010BA);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFE);
    drive(32'h0000FF0F, 32'h0000FF0F, 1'b1, 1'b1, 32'h0001FE1E);
    drive(32'h0F0F0F0F, 32'h00F0F0F1, 1'b1, 1'b1, 32'h10000000);
    drive(32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000);
    drive(32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h00000000);

    reset_pulse();

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_pulse();
      end else begin
        drive($urandom, $urandom, 1'($urandom_range(0, 3) != 0), 1'b0, 32'h0);
      end
    end

    repeat (LAT + 2) @(negedge clk);
    check("drain", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
